// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine with architectural HI/LO registers.
// Shift-add multiply and restoring divide, fixed WIDTH+1 cycle latency.
//
// state  | meaning
// IDLE   | waiting for start; MTHI/MTLO writes accepted
// RUN    | WIDTH iterations, one multiplier/quotient bit per cycle
// FINISH | sign correction, HI/LO write, done pulse

module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] HI_reg,
  output logic [WIDTH-1:0] LO_reg
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FINISH = 2'd2} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd, a_orig, hi_q, lo_q;
  logic               is_div, neg_res, neg_rem, dz_op, dz_flag, done_q;

  logic               sgn_op, sa, sb, last_iter;
  logic [WIDTH-1:0]   mag_a, mag_b, quo, rem;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt, prod;
  logic               unused_diff_bit;

  assign sgn_op = ~op[0];
  assign sa     = sgn_op & srcA[WIDTH-1];
  assign sb     = sgn_op & srcB[WIDTH-1];
  assign mag_a  = sa ? -srcA : srcA;
  assign mag_b  = sb ? -srcB : srcB;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & opnd};
  assign mul_nxt   = {mul_sum, acc[WIDTH-1:1]};
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd};
  assign div_nxt   = div_diff[WIDTH+1] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  // remainder is always below the divisor, so bit WIDTH of a kept difference is zero
  assign unused_diff_bit = div_diff[WIDTH];

  assign prod      = neg_res ? -acc : acc;
  assign quo       = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem       = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (flush) state_nxt = IDLE;
               else if (last_iter) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    if (state != IDLE) busy = 1'b1;
  end

  assign done        = done_q;
  assign div_by_zero = dz_flag;
  assign HI_reg      = hi_q;
  assign LO_reg      = lo_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      a_orig  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz_op   <= 1'b0;
      dz_flag <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi_q <= srcA;
          if (lo_we) lo_q <= srcA;
          if (start) begin
            is_div  <= op[1];
            neg_res <= sa ^ sb;
            neg_rem <= sa;
            dz_op   <= op[1] & (srcB == '0);
            dz_flag <= 1'b0;
            a_orig  <= srcA;
            cnt     <= '0;
            opnd    <= op[1] ? mag_b : mag_a;
            acc     <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
          end
        end
        RUN: begin
          if (!flush) begin
            acc <= is_div ? div_nxt : mul_nxt;
            cnt <= cnt + CNT_W'(1);
          end
        end
        FINISH: begin
          if (!flush) begin
            if (dz_op) begin
              hi_q    <= a_orig;
              lo_q    <= '1;
              dz_flag <= 1'b1;
            end else if (is_div) begin
              hi_q <= rem;
              lo_q <= quo;
            end else begin
              hi_q <= prod[2*WIDTH-1:WIDTH];
              lo_q <= prod[WIDTH-1:0];
            end
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: 32-bit instance for most scenarios,
// 8-bit instance for the narrow-width latency and wrap cases.

module tb_muldiv_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, hi_we, lo_we, flush;
  logic [1:0]  op;
  logic [31:0] srcA, srcB;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  logic        start8, hi_we8, lo_we8, flush8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  muldiv_unit #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .hi_we(hi_we), .lo_we(lo_we), .flush(flush), .busy(busy), .done(done),
    .div_by_zero(dz), .HI_reg(hi), .LO_reg(lo)
  );

  muldiv_unit #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .srcA(a8), .srcB(b8),
    .hi_we(hi_we8), .lo_we(lo_we8), .flush(flush8), .busy(busy8), .done(done8),
    .div_by_zero(dz8), .HI_reg(hi8), .LO_reg(lo8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    longint sa, sb, sr;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    r.dz = 1'b0;
    if (o[1] && b == 32'h0) begin
      r.hi = a; r.lo = 32'hFFFF_FFFF; r.dz = 1'b1;
    end else begin
      case (o)
        2'd0: begin sr = sa * sb; p = sr; r.hi = p[63:32]; r.lo = p[31:0]; end
        2'd1: begin p = ua * ub; r.hi = p[63:32]; r.lo = p[31:0]; end
        2'd2: begin
          sr = sa / sb; p = sr; r.lo = p[31:0];
          sr = sa % sb; p = sr; r.hi = p[31:0];
        end
        default: begin
          p = ua / ub; r.lo = p[31:0];
          p = ua % ub; r.hi = p[31:0];
        end
      endcase
    end
    return r;
  endfunction

  // push expectation, drive start, and return just after the sampling edge
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input exp_t e);
    sbq.push_back(e);
    op = o; srcA = a; srcB = b; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit to);
    cyc = 0; to = 1'b0;
    while (done !== 1'b1) begin
      if (cyc >= 100) begin to = 1'b1; break; end
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 0; hi_we = 0; lo_we = 0; flush = 0; op = 0; srcA = 0; srcB = 0;
    start8 = 0; hi_we8 = 0; lo_we8 = 0; flush8 = 0; op8 = 0; a8 = 0; b8 = 0;
    step(); step();
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || dz !== 1'b0) begin
      n_err++; $display("FAIL reset_ctrl: got busy=%b done=%b dz=%b want 0 0 0", busy, done, dz);
    end
    n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin
      n_err++; $display("FAIL reset_hilo: got %h/%h want 0/0", hi, lo);
    end
    n_cmp++; if (busy8 !== 1'b0 || done8 !== 1'b0 || hi8 !== 8'h0 || lo8 !== 8'h0) begin
      n_err++; $display("FAIL reset_w8: got busy=%b done=%b hi=%h lo=%h want all 0", busy8, done8, hi8, lo8);
    end
    reset = 1'b0;
    step();
    n_cmp++; if (busy !== 1'b0 || hi !== 32'h0) begin
      n_err++; $display("FAIL reset_release: got busy=%b hi=%h want 0/0", busy, hi);
    end
  endtask

  task automatic test_plan_ops();
    logic [1:0]  ov [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
    logic [31:0] av [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'd2};
    logic [31:0] bv [5] = '{32'd5, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd3};
    logic [31:0] eh [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h64, 32'h0};
    logic [31:0] el [5] = '{32'hFFFF_FFF1, 32'h1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd6};
    logic        ed [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_t e;
    int cyc;
    bit to;
    for (int i = 0; i < 5; i++) begin
      e.hi = eh[i]; e.lo = el[i]; e.dz = ed[i];
      launch(ov[i], av[i], bv[i], e);
      wait_done(cyc, to);
      n_cmp++; if (to || cyc != 33) begin
        n_err++; $display("FAIL plan_latency[%0d]: got %0d timeout=%0b want 33", i, cyc, to);
      end
      n_cmp++; if (busy !== 1'b0) begin
        n_err++; $display("FAIL plan_busy_in_done[%0d]: got %b want 0", i, busy);
      end
      e = sbq.pop_front();
      n_cmp++; if (hi !== e.hi || lo !== e.lo || dz !== e.dz) begin
        n_err++; $display("FAIL plan_result[%0d]: got %h/%h dz=%b want %h/%h dz=%b", i, hi, lo, dz, e.hi, e.lo, e.dz);
      end
      step();
      n_cmp++; if (done !== 1'b0) begin
        n_err++; $display("FAIL plan_done_pulse[%0d]: got %b want 0", i, done);
      end
    end
  endtask

  task automatic test_random_ops();
    logic [1:0]  eo [5] = '{2'd2, 2'd0, 2'd2, 2'd3, 2'd2};
    logic [31:0] ea [5] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'd0, 32'd7};
    logic [31:0] eb [5] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'd7, 32'hFFFF_FFFE};
    logic [1:0]  o;
    logic [31:0] a, b;
    exp_t e, x;
    int cyc;
    bit to;
    for (int i = 0; i < 25; i++) begin
      if (i < 5) begin
        o = eo[i]; a = ea[i]; b = eb[i];
      end else begin
        o = 2'($urandom_range(0, 3));
        a = $urandom();
        b = (i % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom();
      end
      e = model(o, a, b);
      launch(o, a, b, e);
      wait_done(cyc, to);
      x = sbq.pop_front();
      n_cmp++; if (to || hi !== x.hi || lo !== x.lo || dz !== x.dz) begin
        n_err++; $display("FAIL rand[%0d] op=%0d a=%h b=%h: got %h/%h dz=%b want %h/%h dz=%b",
                          i, o, a, b, hi, lo, dz, x.hi, x.lo, x.dz);
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ov [3] = '{2'd3, 2'd0, 2'd2};
    logic [31:0] av [3] = '{32'd1000, 32'd12345, 32'hFFFF_FF00};
    logic [31:0] bv [3] = '{32'd7, 32'hFFFF_FFF0, 32'd16};
    exp_t x;
    int cyc;
    bit to;
    launch(ov[0], av[0], bv[0], model(ov[0], av[0], bv[0]));
    for (int i = 0; i < 3; i++) begin
      wait_done(cyc, to);
      n_cmp++; if (to || cyc != 33) begin
        n_err++; $display("FAIL b2b_latency[%0d]: got %0d timeout=%0b want 33", i, cyc, to);
      end
      x = sbq.pop_front();
      n_cmp++; if (hi !== x.hi || lo !== x.lo) begin
        n_err++; $display("FAIL b2b_result[%0d]: got %h/%h want %h/%h", i, hi, lo, x.hi, x.lo);
      end
      if (i < 2) begin
        launch(ov[i+1], av[i+1], bv[i+1], model(ov[i+1], av[i+1], bv[i+1]));
        n_cmp++; if (busy !== 1'b1) begin
          n_err++; $display("FAIL b2b_accept[%0d]: got busy=%b want 1", i, busy);
        end
      end
    end
    step();
  endtask

  task automatic test_ignored_inputs();
    exp_t x;
    int cyc, extra;
    bit to;
    launch(2'd0, 32'hFFFF_FFFD, 32'd5, model(2'd0, 32'hFFFF_FFFD, 32'd5));
    repeat (4) step();
    op = 2'd3; srcA = 32'h1234; srcB = 32'd1;
    start = 1'b1; hi_we = 1'b1; lo_we = 1'b1;
    step();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    wait_done(cyc, to);
    n_cmp++; if (to || cyc + 5 != 33) begin
      n_err++; $display("FAIL ignore_latency: got %0d timeout=%0b want 33", cyc + 5, to);
    end
    x = sbq.pop_front();
    n_cmp++; if (hi !== x.hi || lo !== x.lo) begin
      n_err++; $display("FAIL ignore_result: got %h/%h want %h/%h", hi, lo, x.hi, x.lo);
    end
    extra = 0;
    repeat (40) begin
      step();
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    n_cmp++; if (extra != 0) begin
      n_err++; $display("FAIL ignore_no_queue: got %0d busy/done cycles want 0", extra);
    end
  endtask

  task automatic test_mt_write();
    exp_t x;
    int cyc;
    bit to;
    srcA = 32'hAAAA_5555; hi_we = 1'b1; step(); hi_we = 1'b0;
    n_cmp++; if (hi !== 32'hAAAA_5555) begin
      n_err++; $display("FAIL mthi: got %h want aaaa5555", hi);
    end
    srcA = 32'h1357_2468; lo_we = 1'b1; step(); lo_we = 1'b0;
    n_cmp++; if (lo !== 32'h1357_2468 || hi !== 32'hAAAA_5555) begin
      n_err++; $display("FAIL mtlo: got %h/%h want aaaa5555/13572468", hi, lo);
    end
    hi_we = 1'b1;
    launch(2'd1, 32'd3, 32'd4, model(2'd1, 32'd3, 32'd4));
    hi_we = 1'b0;
    n_cmp++; if (hi !== 32'd3 || busy !== 1'b1) begin
      n_err++; $display("FAIL mthi_with_start: got hi=%h busy=%b want 00000003 1", hi, busy);
    end
    wait_done(cyc, to);
    x = sbq.pop_front();
    n_cmp++; if (to || hi !== x.hi || lo !== x.lo) begin
      n_err++; $display("FAIL mthi_overwrite: got %h/%h want %h/%h", hi, lo, x.hi, x.lo);
    end
    step();
  endtask

  task automatic test_flush();
    exp_t x;
    int cyc, seen;
    bit to;
    srcA = 32'hDEAD_0001; hi_we = 1'b1; step();
    srcA = 32'hBEEF_0002; hi_we = 1'b0; lo_we = 1'b1; step(); lo_we = 1'b0;
    launch(2'd1, 32'd7, 32'd9, model(2'd1, 32'd7, 32'd9));
    x = sbq.pop_back();
    repeat (9) step();
    flush = 1'b1; step(); flush = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin
      n_err++; $display("FAIL flush_run_busy: got %b want 0", busy);
    end
    seen = 0;
    repeat (40) begin step(); if (done === 1'b1) seen++; end
    n_cmp++; if (seen != 0 || hi !== 32'hDEAD_0001 || lo !== 32'hBEEF_0002) begin
      n_err++; $display("FAIL flush_run_hold: got done=%0d %h/%h want 0 dead0001/beef0002", seen, hi, lo);
    end
    launch(2'd3, 32'd50, 32'd0, model(2'd3, 32'd50, 32'd0));
    x = sbq.pop_back();
    repeat (32) step();
    flush = 1'b1; step(); flush = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || dz !== 1'b0 || hi !== 32'hDEAD_0001 || lo !== 32'hBEEF_0002) begin
      n_err++; $display("FAIL flush_finish: got busy=%b done=%b dz=%b %h/%h want 0 0 0 dead0001/beef0002",
                        busy, done, dz, hi, lo);
    end
    flush = 1'b1;
    launch(2'd1, 32'd2, 32'd3, model(2'd1, 32'd2, 32'd3));
    flush = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin
      n_err++; $display("FAIL flush_idle_start: got busy=%b want 1", busy);
    end
    wait_done(cyc, to);
    x = sbq.pop_front();
    n_cmp++; if (to || cyc != 33 || hi !== x.hi || lo !== x.lo) begin
      n_err++; $display("FAIL flush_idle_result: got %0d %h/%h want 33 %h/%h", cyc, hi, lo, x.hi, x.lo);
    end
    step();
  endtask

  task automatic test_reset_midrun();
    srcA = 32'h5555_0000; hi_we = 1'b1; step(); hi_we = 1'b0;
    launch(2'd3, 32'd1000, 32'd3, model(2'd3, 32'd1000, 32'd3));
    repeat (10) step();
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || dz !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_err++; $display("FAIL reset_midrun: got busy=%b done=%b dz=%b %h/%h want all 0", busy, done, dz, hi, lo);
    end
    sbq.delete();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_w8();
    logic [1:0] ov [3] = '{2'd0, 2'd2, 2'd3};
    logic [7:0] av [3] = '{8'h80, 8'h80, 8'hFF};
    logic [7:0] bv [3] = '{8'hFF, 8'hFF, 8'h10};
    logic [7:0] eh [3] = '{8'h00, 8'h00, 8'h0F};
    logic [7:0] el [3] = '{8'h80, 8'h80, 8'h0F};
    exp_t e;
    int cyc;
    for (int i = 0; i < 3; i++) begin
      e.hi = {24'h0, eh[i]}; e.lo = {24'h0, el[i]}; e.dz = 1'b0;
      sbq.push_back(e);
      op8 = ov[i]; a8 = av[i]; b8 = bv[i]; start8 = 1'b1;
      step();
      start8 = 1'b0;
      cyc = 0;
      while (done8 !== 1'b1 && cyc < 50) begin step(); cyc++; end
      n_cmp++; if (cyc != 9) begin
        n_err++; $display("FAIL w8_latency[%0d]: got %0d want 9", i, cyc);
      end
      e = sbq.pop_front();
      n_cmp++; if ({24'h0, hi8} !== e.hi || {24'h0, lo8} !== e.lo || dz8 !== e.dz) begin
        n_err++; $display("FAIL w8_result[%0d]: got %h/%h dz=%b want %h/%h dz=%b",
                          i, hi8, lo8, dz8, e.hi[7:0], e.lo[7:0], e.dz);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_plan_ops();
    test_random_ops();
    test_back_to_back();
    test_ignored_inputs();
    test_mt_write();
    test_flush();
    test_reset_midrun();
    test_w8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
